// File: rtl/rfe_ctrl.sv
// rtl/rfe_ctrl.sv - return-from-exception drain/redirect sequencer
//
// Purpose: on a decode-stage RFE, latch the saved return address, flush the
// pipe for DRAIN_CYCLES cycles, then hold a fetch redirect until the fetch
// stage acknowledges it, re-enabling interrupts on completion. A new
// exception aborts the sequence at any point and clears the interrupt enable.
//
// Ports:
//   clk         - single clock, rising edge
//   reset       - synchronous, active-high
//   rfe_req     - RFE instruction valid in decode
//   iar_in      - saved exception return address
//   exc_in      - exception being taken this cycle
//   pc_ack      - fetch stage accepts the redirect
//   busy        - sequence in progress (non-IDLE)
//   flush       - kill younger in-flight instructions
//   pc_redirect - pc_target valid
//   pc_target   - return fetch address (safe vector if misaligned)
//   int_enable  - interrupt enable flag
//   addr_err    - latched return address was misaligned
module rfe_ctrl #(
   parameter int unsigned DRAIN_CYCLES = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rfe_req,
   input  logic [31:0] iar_in,
   input  logic        exc_in,
   input  logic        pc_ack,
   output logic        busy,
   output logic        flush,
   output logic        pc_redirect,
   output logic [31:0] pc_target,
   output logic        int_enable,
   output logic        addr_err
);

   localparam logic [31:0] SAFE_PC  = 32'h0001_0000;
   localparam logic [3:0]  CNT_LOAD = 4'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRAIN,
      S_REDIRECT
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] iar_q, iar_d;
   logic [31:0] pc_target_q, pc_target_d;
   logic        busy_q, busy_d;
   logic        flush_q, flush_d;
   logic        pc_redirect_q, pc_redirect_d;
   logic        int_enable_q, int_enable_d;
   logic        addr_err_q, addr_err_d;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      iar_d         = iar_q;
      pc_target_d   = pc_target_q;
      int_enable_d  = int_enable_q;
      addr_err_d    = addr_err_q;
      flush_d       = 1'b0;
      pc_redirect_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            // An exception in the same cycle as an RFE wins outright.
            if (exc_in) begin
               int_enable_d = 1'b0;
            end else if (rfe_req) begin
               iar_d   = iar_in;
               cnt_d   = CNT_LOAD;
               state_d = S_DRAIN;
               flush_d = 1'b1;
            end
         end
         S_DRAIN: begin
            if (exc_in) begin
               int_enable_d = 1'b0;
               state_d      = S_IDLE;
            end else if (cnt_q == 4'd0) begin
               // Decide the target once, on entry, so it is stable for the
               // whole redirect window.
               state_d       = S_REDIRECT;
               pc_redirect_d = 1'b1;
               addr_err_d    = |iar_q[1:0];
               pc_target_d   = (|iar_q[1:0]) ? SAFE_PC : iar_q;
            end else begin
               cnt_d   = cnt_q - 4'd1;
               flush_d = 1'b1;
            end
         end
         S_REDIRECT: begin
            // exc_in is checked first so it beats a simultaneous pc_ack.
            if (exc_in) begin
               int_enable_d = 1'b0;
               addr_err_d   = 1'b0;
               state_d      = S_IDLE;
            end else if (pc_ack) begin
               int_enable_d = 1'b1;
               addr_err_d   = 1'b0;
               state_d      = S_IDLE;
            end else begin
               pc_redirect_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         cnt_q         <= 4'd0;
         iar_q         <= SAFE_PC;
         pc_target_q   <= SAFE_PC;
         busy_q        <= 1'b0;
         flush_q       <= 1'b0;
         pc_redirect_q <= 1'b0;
         int_enable_q  <= 1'b0;
         addr_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         iar_q         <= iar_d;
         pc_target_q   <= pc_target_d;
         busy_q        <= busy_d;
         flush_q       <= flush_d;
         pc_redirect_q <= pc_redirect_d;
         int_enable_q  <= int_enable_d;
         addr_err_q    <= addr_err_d;
      end
   end

   assign busy        = busy_q;
   assign flush       = flush_q;
   assign pc_redirect = pc_redirect_q;
   assign pc_target   = pc_target_q;
   assign int_enable  = int_enable_q;
   assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_rfe_ctrl.sv
// tb/tb_rfe_ctrl.sv - self-checking bench for rfe_ctrl (DRAIN_CYCLES 3, 1, 15)
module tb_rfe_ctrl;

   localparam logic [31:0] SAFE = 32'h0001_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rfe_req = 1'b0;
   logic [31:0] iar_in = 32'h0;
   logic        exc_in = 1'b0;
   logic        pc_ack = 1'b0;

   logic [2:0]  busy_w, flush_w, red_w, ie_w, aerr_w;
   logic [31:0] tgt_w [3];

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   rfe_ctrl #(.DRAIN_CYCLES(3)) u_dc3 (
      .clk(clk), .reset(reset), .rfe_req(rfe_req), .iar_in(iar_in),
      .exc_in(exc_in), .pc_ack(pc_ack), .busy(busy_w[0]), .flush(flush_w[0]),
      .pc_redirect(red_w[0]), .pc_target(tgt_w[0]), .int_enable(ie_w[0]),
      .addr_err(aerr_w[0]));
   rfe_ctrl #(.DRAIN_CYCLES(1)) u_dc1 (
      .clk(clk), .reset(reset), .rfe_req(rfe_req), .iar_in(iar_in),
      .exc_in(exc_in), .pc_ack(pc_ack), .busy(busy_w[1]), .flush(flush_w[1]),
      .pc_redirect(red_w[1]), .pc_target(tgt_w[1]), .int_enable(ie_w[1]),
      .addr_err(aerr_w[1]));
   rfe_ctrl #(.DRAIN_CYCLES(15)) u_dc15 (
      .clk(clk), .reset(reset), .rfe_req(rfe_req), .iar_in(iar_in),
      .exc_in(exc_in), .pc_ack(pc_ack), .busy(busy_w[2]), .flush(flush_w[2]),
      .pc_redirect(red_w[2]), .pc_target(tgt_w[2]), .int_enable(ie_w[2]),
      .addr_err(aerr_w[2]));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a sequence is an accepted request with a start edge
   // index; outputs follow from its age in edges.
   int          dcs [3] = '{3, 1, 15};
   bit          m_busy [3];
   int          m_start [3];
   logic [31:0] m_addr [3];
   logic [31:0] m_tgt [3];
   bit          m_ie [3];
   int          n = 0;
   bit          armed = 1'b0;

   always @(posedge clk) begin
      n = n + 1;
      if (reset) armed = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if (reset) begin
            m_busy[k] = 1'b0;
            m_ie[k]   = 1'b0;
            m_tgt[k]  = SAFE;
         end else if (exc_in) begin
            m_busy[k] = 1'b0;
            m_ie[k]   = 1'b0;
         end else if (!m_busy[k]) begin
            if (rfe_req) begin
               m_busy[k]  = 1'b1;
               m_start[k] = n;
               m_addr[k]  = iar_in;
            end
         end else if ((n - m_start[k]) > dcs[k] && pc_ack) begin
            m_busy[k] = 1'b0;
            m_ie[k]   = 1'b1;
         end
         if (m_busy[k] && (n - m_start[k]) == dcs[k])
            m_tgt[k] = (m_addr[k][1:0] == 2'b00) ? m_addr[k] : SAFE;
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         for (int k = 0; k < 3; k++) begin
            int  age;
            bit  e_flush, e_red;
            age     = n - m_start[k];
            e_flush = m_busy[k] && (age < dcs[k]);
            e_red   = m_busy[k] && (age >= dcs[k]);
            chk($sformatf("model_busy[%0d]", k), 32'(busy_w[k]), 32'(m_busy[k]));
            chk($sformatf("model_flush[%0d]", k), 32'(flush_w[k]), 32'(e_flush));
            chk($sformatf("model_redirect[%0d]", k), 32'(red_w[k]), 32'(e_red));
            chk($sformatf("model_addr_err[%0d]", k), 32'(aerr_w[k]),
                32'(e_red && (m_addr[k][1:0] != 2'b00)));
            chk($sformatf("model_int_enable[%0d]", k), 32'(ie_w[k]), 32'(m_ie[k]));
            chk($sformatf("model_pc_target[%0d]", k), tgt_w[k], m_tgt[k]);
         end
      end
   end

   task automatic tick(input logic r, input logic [31:0] ia, input logic x,
                       input logic a, input logic rs);
      @(negedge clk);
      rfe_req = r;
      iar_in  = ia;
      exc_in  = x;
      pc_ack  = a;
      reset   = rs;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int cnt);
      for (int i = 0; i < cnt; i++) tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int fcnt [3];

      // Reset values
      tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      chk("rst_busy", 32'(busy_w[0]), 32'd0);
      chk("rst_flush", 32'(flush_w[0]), 32'd0);
      chk("rst_redirect", 32'(red_w[0]), 32'd0);
      chk("rst_addr_err", 32'(aerr_w[0]), 32'd0);
      chk("rst_int_enable", 32'(ie_w[0]), 32'd0);
      chk("rst_pc_target", tgt_w[0], SAFE);

      // Basic return, DRAIN_CYCLES=3: flush T+1..T+3, redirect from T+4
      tick(1'b1, 32'h0001_0040, 1'b0, 1'b0, 1'b0);
      chk("basic_flush1", 32'(flush_w[0]), 32'd1);
      chk("basic_busy1", 32'(busy_w[0]), 32'd1);
      chk("dc1_flush1", 32'(flush_w[1]), 32'd1);
      idle(1);
      chk("basic_flush2", 32'(flush_w[0]), 32'd1);
      chk("dc1_redirect", 32'(red_w[1]), 32'd1);
      idle(1);
      chk("basic_flush3", 32'(flush_w[0]), 32'd1);
      chk("basic_no_redirect_yet", 32'(red_w[0]), 32'd0);
      idle(1);
      chk("basic_flush_off", 32'(flush_w[0]), 32'd0);
      chk("basic_redirect", 32'(red_w[0]), 32'd1);
      chk("basic_target", tgt_w[0], 32'h0001_0040);
      idle(2);
      chk("basic_redirect_hold", 32'(red_w[0]), 32'd1);
      chk("basic_target_hold", tgt_w[0], 32'h0001_0040);
      tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      chk("basic_ack_busy", 32'(busy_w[0]), 32'd0);
      chk("basic_ack_redirect", 32'(red_w[0]), 32'd0);
      chk("basic_ack_int_enable", 32'(ie_w[0]), 32'd1);
      chk("basic_idle_target", tgt_w[0], 32'h0001_0040);

      // Collision in REDIRECT: exc_in beats pc_ack
      tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      tick(1'b1, 32'h0001_0100, 1'b0, 1'b0, 1'b0);
      idle(4);
      tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      chk("pre_coll_int_enable", 32'(ie_w[0]), 32'd1);
      tick(1'b1, 32'h0001_0200, 1'b0, 1'b0, 1'b0);
      idle(3);
      tick(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      chk("coll_busy", 32'(busy_w[0]), 32'd0);
      chk("coll_redirect", 32'(red_w[0]), 32'd0);
      chk("coll_int_enable", 32'(ie_w[0]), 32'd0);

      // Misaligned return
      tick(1'b1, 32'h0001_0042, 1'b0, 1'b0, 1'b0);
      idle(3);
      chk("mis_addr_err", 32'(aerr_w[0]), 32'd1);
      chk("mis_target", tgt_w[0], SAFE);
      chk("mis_redirect", 32'(red_w[0]), 32'd1);
      tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      chk("mis_ack_addr_err", 32'(aerr_w[0]), 32'd0);
      chk("mis_ack_int_enable", 32'(ie_w[0]), 32'd1);

      // Abort at second DRAIN cycle
      tick(1'b1, 32'h0001_0300, 1'b0, 1'b0, 1'b0);
      idle(1);
      tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      chk("abort_busy", 32'(busy_w[0]), 32'd0);
      chk("abort_flush", 32'(flush_w[0]), 32'd0);
      chk("abort_int_enable", 32'(ie_w[0]), 32'd0);
      idle(4);
      chk("abort_no_redirect", 32'(red_w[0]), 32'd0);

      // Collision in IDLE: rfe_req with exc_in starts nothing
      tick(1'b1, 32'h0001_0400, 1'b1, 1'b0, 1'b0);
      chk("idle_coll_busy", 32'(busy_w[0]), 32'd0);
      idle(1);
      chk("idle_coll_busy2", 32'(busy_w[0]), 32'd0);

      // Reset mid-REDIRECT, then a clean sequence
      tick(1'b1, 32'h0001_0500, 1'b0, 1'b0, 1'b0);
      idle(4);
      tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      chk("midrst_busy", 32'(busy_w[0]), 32'd0);
      chk("midrst_redirect", 32'(red_w[0]), 32'd0);
      chk("midrst_target", tgt_w[0], SAFE);
      chk("midrst_int_enable", 32'(ie_w[0]), 32'd0);
      tick(1'b1, 32'h0001_0600, 1'b0, 1'b0, 1'b0);
      idle(3);
      chk("postrst_redirect", 32'(red_w[0]), 32'd1);
      chk("postrst_target", tgt_w[0], 32'h0001_0600);
      tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      chk("postrst_int_enable", 32'(ie_w[0]), 32'd1);

      // Flush-cycle counts with rfe_req pulses while busy
      tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      tick(1'b1, 32'h0001_0080, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) fcnt[k] = int'(flush_w[k]);
      for (int i = 0; i < 20; i++) begin
         tick(1'($urandom_range(0, 1)), $urandom, 1'b0, 1'b0, 1'b0);
         for (int k = 0; k < 3; k++) fcnt[k] += int'(flush_w[k]);
      end
      chk("flush_count_dc3", 32'(fcnt[0]), 32'd3);
      chk("flush_count_dc1", 32'(fcnt[1]), 32'd1);
      chk("flush_count_dc15", 32'(fcnt[2]), 32'd15);
      chk("dc15_target_kept", tgt_w[2], 32'h0001_0080);
      tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] ia;
         ia = $urandom;
         if ($urandom_range(0, 1) == 0) ia[1:0] = 2'b00;
         tick(1'($urandom_range(0, 2) == 0), ia,
              1'($urandom_range(0, 24) == 0),
              1'($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 199) == 0));
      end

      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/rfe_ctrl.md
RFE_CTRL -- requirements
Module: rfe_ctrl

Interface
REQ-001 The block SHALL have parameter DRAIN_CYCLES, default 3, meaning the number of flush cycles before redirect; legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-004 The block SHALL have port rfe_req, input, 1, decode-stage return-from-exception instruction valid.
REQ-005 The block SHALL have port iar_in, input, 32, saved exception return address from the interrupt address register.
REQ-006 The block SHALL have port exc_in, input, 1, new exception being taken this cycle.
REQ-007 The block SHALL have port pc_ack, input, 1, fetch stage accepts the redirect.
REQ-008 The block SHALL have port busy, output, 1, high in any non-IDLE state.
REQ-009 The block SHALL have port flush, output, 1, kill younger in-flight instructions.
REQ-010 The block SHALL have port pc_redirect, output, 1, pc_target valid.
REQ-011 The block SHALL have port pc_target, output, 32, return fetch address.
REQ-012 The block SHALL have port int_enable, output, 1, interrupt enable flag.
REQ-013 The block SHALL have port addr_err, output, 1, latched return address illegal.

Function
REQ-014 The block SHALL implement states IDLE, DRAIN and REDIRECT; all outputs SHALL be registered.
REQ-015 In IDLE, rfe_req=1 with exc_in=0 SHALL latch iar_in, load a 4-bit counter with DRAIN_CYCLES-1, and enter DRAIN next cycle.
REQ-016 In DRAIN, flush and busy SHALL be 1; the counter SHALL decrement each cycle; the state SHALL advance to REDIRECT on the cycle after the counter reads 0, giving exactly DRAIN_CYCLES flush cycles.
REQ-017 Latency SHALL be fixed: rfe_req sampled at edge T gives flush high over T+1..T+DRAIN_CYCLES and pc_redirect high from T+DRAIN_CYCLES+1.
REQ-018 In REDIRECT, pc_redirect and busy SHALL be 1, flush SHALL be 0, and pc_target SHALL hold stable until pc_ack.
REQ-019 pc_ack=1 in REDIRECT SHALL return the block to IDLE, deassert pc_redirect, and set int_enable=1 on the same edge.
REQ-020 pc_ack outside REDIRECT SHALL be ignored.
REQ-021 A latched address with bits [1:0] not equal to 0 SHALL set addr_err=1 for the whole REDIRECT state, and pc_target SHALL then be 32'h0001_0000 instead of the latched value.
REQ-022 addr_err SHALL clear on the exit from REDIRECT.
REQ-023 exc_in=1 SHALL clear int_enable on the next edge in any state.
REQ-024 exc_in=1 in DRAIN or REDIRECT SHALL abort the sequence: next state IDLE, flush and pc_redirect 0, no int_enable set; exc_in SHALL win over a simultaneous pc_ack.
REQ-025 rfe_req and exc_in in the same IDLE cycle SHALL take the exception only, with no sequence started.
REQ-026 rfe_req while busy=1 SHALL be ignored, with no queuing.
REQ-027 pc_target SHALL retain its last value in IDLE.

Reset
REQ-028 reset=1 at a clock edge SHALL force IDLE with counter=0, busy=0, flush=0, pc_redirect=0, addr_err=0, int_enable=0 and pc_target=32'h0001_0000.
REQ-029 reset SHALL dominate every other input, including reset asserted mid-DRAIN or mid-REDIRECT.
REQ-030 reset SHALL be sampled only at the clock edge.

Verification
REQ-031 Basic return (DRAIN_CYCLES=3): rfe_req with iar_in=32'h0001_0040 at T -> flush high T+1..T+3; pc_redirect high with pc_target=32'h0001_0040 from T+4; pc_ack at T+6 -> IDLE and int_enable=1 at T+7.
REQ-032 Misaligned return: iar_in=32'h0001_0042 -> addr_err=1 and pc_target=32'h0001_0000 during REDIRECT; addr_err=0 after ack.
REQ-033 Abort: exc_in at the second DRAIN cycle -> IDLE next cycle, with pc_redirect never asserted and int_enable=0.
REQ-034 Collision: exc_in together with pc_ack in REDIRECT -> IDLE with int_enable=0; exc_in together with rfe_req in IDLE -> busy stays 0.
REQ-035 Reset mid-REDIRECT: reset high for one edge -> all outputs at reset values next cycle; a subsequent rfe_req runs the full sequence normally.
REQ-036 Parameter corner: DRAIN_CYCLES=1 -> exactly one flush cycle; DRAIN_CYCLES=15 -> exactly 15 flush cycles; rfe_req pulses during busy are ignored in both cases.
